// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises one data access (possibly split across two 8-byte words) and one
// instruction fetch per request onto a single-ported 64-bit synchronous SRAM.
// Byte lane k of every 64-bit bus sits at bits [63-8k:56-8k] (lane 0 is the MSB byte).
// sram_be bit i gates sram_wdata[8i+7:8i], so lane k is enabled by sram_be[7-k].
module mem_ctrl #(
  parameter int unsigned PLEN = 64,
  parameter int unsigned DLEN = 64,
  parameter int unsigned ILEN = 32,
  parameter int unsigned AW   = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req,
  output logic            ack,
  input  logic [PLEN-1:0] paddr,
  input  logic [DLEN-1:0] dout_ram,
  input  logic [1:0]      dlen_ram,
  input  logic            we_ram,
  input  logic            re_ram,
  output logic [DLEN-1:0] din_back,
  input  logic [PLEN-1:0] iaddr_ram,
  output logic [ILEN-1:0] iin_back,
  output logic            sram_en,
  output logic            sram_we,
  output logic [7:0]      sram_be,
  output logic [AW-1:0]   sram_addr,
  output logic [63:0]     sram_wdata,
  input  logic [63:0]     sram_rdata
);

  typedef enum logic [2:0] {StIdle, StDLo, StDHi, StIRd, StICap, StDone} state_e;

  state_e state_q, state_d;

  // Request latched at accept
  logic [AW+2:0] dadr_q;
  logic [AW:0]   fadr_q;   // fetch address bits [AW+2:2]
  logic [63:0]   dout_q;
  logic [1:0]    dlen_q;
  logic          wr_q;
  logic          rd_q;     // load only; a store wins over a simultaneous load

  // Raw read words and returned results
  logic [63:0]   lo_q, hi_q;
  logic [63:0]   din_q;
  logic [31:0]   iin_q;

  logic          unused_addr_bits;
  assign unused_addr_bits = ^{paddr[PLEN-1:AW+3], iaddr_ram[PLEN-1:AW+3], iaddr_ram[1:0]};

  // Access geometry
  logic [2:0]    off;
  logic [AW-1:0] word;
  logic [7:0]    len_mask;   // N lanes starting at lane 0, MSB-first
  logic [15:0]   span;       // lanes of the low word (upper byte) and high word (lower byte)
  logic          straddle;
  logic [63:0]   wdata_lo, wdata_hi;
  logic [127:0]  load_win;
  logic [63:0]   load_data;
  logic [31:0]   fetch_word;

  assign off  = dadr_q[2:0];
  assign word = dadr_q[AW+2:3];

  // Size decode into a lane mask
  always_comb begin
    len_mask = 8'hFF;
    unique case (dlen_q)
      2'd0:    len_mask = 8'h80;
      2'd1:    len_mask = 8'hC0;
      2'd2:    len_mask = 8'hF0;
      default: len_mask = 8'hFF;
    endcase
  end

  assign span     = {len_mask, 8'h00} >> off;
  assign straddle = |span[7:0];
  assign wdata_lo = dout_q >> {off, 3'b000};
  assign wdata_hi = dout_q << (7'd64 - {1'b0, off, 3'b000});
  assign load_win = {lo_q, hi_q} << {off, 3'b000};
  assign fetch_word = fadr_q[0] ? sram_rdata[31:0] : sram_rdata[63:32];

  // Align the loaded bytes to lane 0 and zero the lanes beyond the access size
  always_comb begin
    load_data = '0;
    for (int k = 0; k < 8; k++) begin
      if (len_mask[7-k]) load_data[63-8*k -: 8] = load_win[127-8*k -: 8];
    end
  end

  // Next state and SRAM command; an asserted reset suppresses any issue this cycle
  always_comb begin
    state_d    = state_q;
    ack        = 1'b0;
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_be    = 8'h00;
    sram_addr  = '0;
    sram_wdata = '0;
    unique case (state_q)
      StIdle: begin
        if (req) state_d = (re_ram || we_ram) ? StDLo : StIRd;
      end
      StDLo: begin
        sram_en    = 1'b1;
        sram_we    = wr_q;
        sram_be    = wr_q ? span[15:8] : 8'hFF;
        sram_addr  = word;
        sram_wdata = wr_q ? wdata_lo : '0;
        state_d    = straddle ? StDHi : StIRd;
      end
      StDHi: begin
        sram_en    = 1'b1;
        sram_we    = wr_q;
        sram_be    = wr_q ? span[7:0] : 8'hFF;
        sram_addr  = word + AW'(1);
        sram_wdata = wr_q ? wdata_hi : '0;
        state_d    = StIRd;
      end
      StIRd: begin
        sram_en   = 1'b1;
        sram_be   = 8'hFF;
        sram_addr = fadr_q[AW:1];
        state_d   = StICap;
      end
      StICap: state_d = StDone;
      StDone: begin
        ack     = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (!rst_n) begin
      ack        = 1'b0;
      sram_en    = 1'b0;
      sram_we    = 1'b0;
      sram_be    = 8'h00;
      sram_addr  = '0;
      sram_wdata = '0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Request latch, read-data capture and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dadr_q <= '0;
      fadr_q <= '0;
      dout_q <= '0;
      dlen_q <= '0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      lo_q   <= '0;
      hi_q   <= '0;
      din_q  <= '0;
      iin_q  <= '0;
    end else begin
      if (state_q == StIdle && req) begin
        dadr_q <= paddr[AW+2:0];
        fadr_q <= iaddr_ram[AW+2:2];
        dout_q <= dout_ram;
        dlen_q <= dlen_ram;
        wr_q   <= we_ram;
        rd_q   <= re_ram & ~we_ram;
      end
      if (state_q == StDHi) lo_q <= sram_rdata;
      // Data read issued in the previous cycle: the high word if split, else the low word
      if (state_q == StIRd && rd_q) begin
        if (straddle) hi_q <= sram_rdata;
        else          lo_q <= sram_rdata;
      end
      if (state_q == StICap) begin
        iin_q <= fetch_word;
        din_q <= rd_q ? load_data : '0;
      end
    end
  end

  assign din_back = din_q;
  assign iin_back = iin_q;

endmodule
